// File: rtl/my_ram_dump.sv
// ============================================================================
// Module   : my_ram_dump
// Purpose  : Walks len RAM words from base (wrapping) onto a valid/ready stream.
// Options  : MY_RAM_DUMP_CHECKSUM_EN builds the running checksum of sent words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module my_ram_dump #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [WIDTH-1:0]  ram_out,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [WIDTH-1:0]    r_out;
  logic                r_out_valid;
  logic                r_out_last;
  logic [ADDR_W:0]     w_len_clamped;
  logic                w_accept;
  logic                w_handshake;

  // Encodings above DEPTH cannot be meaningful word counts; cap to a full sweep.
  assign w_len_clamped = (len > C_DEPTH) ? C_DEPTH : len;
  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_handshake   = (r_state == S_SEND) && r_out_valid && out_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (w_len_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: w_next_state = S_SEND;
      S_SEND: begin
        if (w_handshake) begin
          w_next_state = r_out_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ram_addr  <= '0;
      r_remaining <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ram_addr  <= base;
            r_remaining <= w_len_clamped;
          end
        end
        S_FETCH: begin
          r_out       <= ram_out;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_remaining == C_ONE);
        end
        S_SEND: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (!r_out_last) begin
              // Power-of-two DEPTH makes the natural overflow the modulo wrap.
              r_ram_addr  <= r_ram_addr + ADDR_W'(1);
              r_remaining <= r_remaining - C_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MY_RAM_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_handshake) begin
      r_checksum <= r_checksum + r_out;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign ram_addr  = r_ram_addr;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_my_ram_dump.sv
// ============================================================================
// Module   : tb_my_ram_dump
// Purpose  : Randomized and directed checks of my_ram_dump against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_my_ram_dump;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_out;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  checksum;

  logic [WIDTH-1:0]  mem [DEPTH];
  int                n_total = 0;
  int                n_bad   = 0;

  always #5 clk = ~clk;

  assign ram_out = mem[ram_addr];

  my_ram_dump #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .len       (len),
    .ram_addr  (ram_addr),
    .ram_out   (ram_out),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: three stall cycles per word
  task automatic run_dump(input int b, input int l, input int mode,
                          input bit spurious, input bit scribble);
    logic [WIDTH-1:0] exp_q[$];
    int               exp_a[$];
    logic [WIDTH-1:0] exp_sum;
    logic [WIDTH-1:0] prev_out;
    bit               prev_stall;
    bit               prev_last_hs;
    bit               finished;
    int               n;
    int               stall;

    n = (l > DEPTH) ? DEPTH : l;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back((b + i) % DEPTH);
      exp_q.push_back(mem[(b + i) % DEPTH]);
      exp_sum = exp_sum + mem[(b + i) % DEPTH];
    end
`ifndef MY_RAM_DUMP_CHECKSUM_EN
    exp_sum = '0;
`endif

    start     = 1'b1;
    base      = ADDR_W'(b);
    len       = (ADDR_W+1)'(l);
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("addr_after_start", ram_addr, b);
    check_eq("valid_after_start", out_valid, 0);

    if (n == 0) begin
      check_eq("done_len0", done, 1);
      @(posedge clk); #1;
      check_eq("done_len0_end", done, 0);
      check_eq("busy_len0_end", busy, 0);
      check_eq("cksum_len0", checksum, exp_sum);
      return;
    end

    check_eq("done_early", done, 0);
    prev_stall   = 1'b0;
    prev_last_hs = 1'b0;
    prev_out     = '0;
    finished     = 1'b0;
    stall        = 0;
    for (int k = 1; k < 400 && !finished; k++) begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && stall < 3) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      start = spurious && !done;
      if (spurious) begin
        base = ADDR_W'(2);
        len  = (ADDR_W+1)'(3);
      end
      if (scribble && out_valid) mem[ram_addr] = WIDTH'($urandom);
      @(negedge clk);
      if (k == 1) check_eq("first_valid", out_valid, 1);
      if (prev_stall) check_eq("stall_hold", out, prev_out);
      check_eq("done_timing", done, prev_last_hs);
      prev_last_hs = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", out_valid, 0);
        end else begin
          check_eq("word", out, exp_q[0]);
          check_eq("addr", ram_addr, exp_a[0]);
          check_eq("last", out_last, exp_q.size() == 1);
          prev_last_hs = (exp_q.size() == 1);
          void'(exp_q.pop_front());
          void'(exp_a.pop_front());
          stall = 0;
        end
      end
      if (done) begin
        finished = 1'b1;
        check_eq("words_left", exp_q.size(), 0);
        check_eq("cksum_done", checksum, exp_sum);
        check_eq("valid_at_done", out_valid, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
    if (!finished) check_eq("timeout", finished, 1);

    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);
    check_eq("cksum_hold", checksum, exp_sum);
  endtask

  task automatic reset_mid_dump();
    bit seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    start     = 1'b1;
    base      = '0;
    len       = (ADDR_W+1)'(8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) seen = 1'b1;
    end
    check_eq("rst_first_hs", seen, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_second_valid", out_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_out", out, 0);
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_cksum", checksum, 0);
    check_eq("rst_done", done, 0);
    @(posedge clk); #1;
    check_eq("rst_no_done", done, 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base      = '0;
    len       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("reset_addr", ram_addr, 0);
    check_eq("reset_out", out, 0);
    check_eq("reset_valid", out_valid, 0);
    check_eq("reset_last", out_last, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_cksum", checksum, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("idle_busy_hold", busy, 0);
      check_eq("idle_valid_hold", out_valid, 0);
    end

    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i * 1000);
    run_dump(0, 8, 0, 1'b0, 1'b0);

    mem[6] = WIDTH'(-32123);
    mem[7] = WIDTH'(11111);
    mem[0] = WIDTH'(12345);
    run_dump(6, 3, 2, 1'b0, 1'b0);

    run_dump(5, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    run_dump(0, 4, 0, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    run_dump(3, 12, 1, 1'b0, 1'b0);

    reset_mid_dump();
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    run_dump(1, 5, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
      run_dump(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
